status_register: RTL
====================

// Module: status_register
// PURPOSE
//  Holds the architectural condition flags N, ZF, C, V and drives them to the
//  condition tester (upstream neighbour of the condition tester). Accepts flag
//  updates from the ALU (S-bit instructions), logical-op updates with shifter carry,
//  and direct flag writes (MSR-style). With COMMIT_LAT=2 an update is staged for
//  one cycle, and Pending stalls condition evaluation until the update commits.
// PARAMETERS
//  COMMIT_LAT  1  cycles from update request to visible flags (legal: 1 or 2)
// PORTS
//  Clk        in   1  rising-edge clock
//  Clr        in   1  asynchronous reset, active-low
//  Ld_S       in   1  ALU flag update request (instruction S bit)
//  Logic_op   in   1  with Ld_S: logical op; C from Shift_C, V unchanged
//  ALU_N      in   1  ALU negative result
//  ALU_Z      in   1  ALU zero result
//  ALU_C      in   1  ALU carry out
//  ALU_V      in   1  ALU overflow
//  Shift_C    in   1  shifter carry out (used when Logic_op=1)
//  Ld_direct  in   1  direct flag write request
//  D_flags    in   4  direct value {N,Z,C,V} = [3:0]
//  Stall      in   1  blocks capture of new requests; in-flight commit continues
//  Flush      in   1  discards staged update and this cycle's request
//  N,ZF,C,V   out  1  committed flags, to condition tester
//  Flags      out  4  {N,ZF,C,V} copy of committed flags
//  Pending    out  1  staged update not yet visible (always 0 if COMMIT_LAT=1)
// BEHAVIOUR
//  - Reset (Clr=0, asynchronous): N=ZF=C=V=0, Flags=4'b0000, Pending=0, stage empty.
//    Reset asserted mid-operation discards any staged update.
//  - Request = (Ld_S | Ld_direct) & ~Stall & ~Flush. Ld_direct has priority over Ld_S.
//  - New value: Ld_direct -> D_flags. Ld_S&~Logic_op -> {ALU_N,ALU_Z,ALU_C,ALU_V}.
//    Ld_S&Logic_op -> {ALU_N,ALU_Z,Shift_C,Vnew}. Vnew is the staged V if the stage
//    is valid and not flushed, else the committed V.
//  - COMMIT_LAT=1: on the clock edge of a request, flags <= new value. No other change.
//  - COMMIT_LAT=2: two states, EMPTY / STAGED (Pending = STAGED).
//    EMPTY: request -> capture into stage, go STAGED; else stay EMPTY.
//    STAGED: on the next edge the flags take the stage value. If a request is present
//      in the same cycle, capture it and stay STAGED (back-to-back, one per cycle).
//      Otherwise go EMPTY.
//    Flush in STAGED: no commit, stage cleared, go EMPTY; flags unchanged.
//  - Stall does not freeze the stage: a staged update still commits while Stall=1.
//  - Outputs are registered only; no combinational path from inputs to N/ZF/C/V.
//  - Flags always equals {N,ZF,C,V}.
// TESTING
//  1 Clr=0 then release -> N,ZF,C,V=0, Pending=0; Clr pulse while STAGED -> stage lost, flags 0.
//  2 LAT=1: Ld_S, ALU={1,0,1,1} -> Flags=4'b1011 the next cycle; idle cycles -> holds.
//  3 Flags=4'b0001, Ld_S+Logic_op, ALU_N=0,ALU_Z=1,Shift_C=1 -> Flags=4'b0111 (V kept).
//  4 Ld_S (ALU 1100) and Ld_direct (D_flags 0011) in the same cycle -> Flags=4'b0011.
//  5 LAT=2: request 1000 -> Pending=1 for 1 cycle, then Flags=4'b1000, Pending=0;
//    back-to-back 1000,0100 -> Flags 1000 then 0100, Pending=1 for both cycles.
//  6 LAT=2: request 0110, then Flush next cycle -> Flags unchanged, Pending=0;
//    Stall with request -> no capture; Stall while STAGED -> commit still occurs.

Source files
------------

// File: rtl/status_register_if.sv
// Flag-update request bus into the status register, and the committed flag view
// it drives to the condition tester.
interface status_register_if;
    logic       Ld_S;
    logic       Logic_op;
    logic       ALU_N;
    logic       ALU_Z;
    logic       ALU_C;
    logic       ALU_V;
    logic       Shift_C;
    logic       Ld_direct;
    logic [3:0] D_flags;
    logic       Stall;
    logic       Flush;
    logic       N;
    logic       ZF;
    logic       C;
    logic       V;
    logic [3:0] Flags;
    logic       Pending;

    modport master (
        output Ld_S, Logic_op, ALU_N, ALU_Z, ALU_C, ALU_V, Shift_C,
        output Ld_direct, D_flags, Stall, Flush,
        input  N, ZF, C, V, Flags, Pending
    );

    modport slave (
        input  Ld_S, Logic_op, ALU_N, ALU_Z, ALU_C, ALU_V, Shift_C,
        input  Ld_direct, D_flags, Stall, Flush,
        output N, ZF, C, V, Flags, Pending
    );
endinterface

// File: rtl/status_register.sv
// Architectural N/Z/C/V condition flags with ALU, logical-op and direct updates.
// COMMIT_LAT=2 stages each update for one cycle and flags it via Pending.
module status_register #(
    parameter int COMMIT_LAT = 1
) (
    input  logic          Clk,
    input  logic          Clr,
    status_register_if.slave bus
);
    logic [3:0] r_flags;
    logic       r_pending;
    logic [3:0] r_stage;
    logic       w_stage_valid;
    logic       w_req;
    logic       w_v_base;
    logic [3:0] w_new;

    assign w_req = (bus.Ld_S | bus.Ld_direct) & ~bus.Stall & ~bus.Flush;

    // A logical op keeps V from the most recent update, which may still be staged.
    assign w_v_base = (w_stage_valid && !bus.Flush) ? r_stage[0] : r_flags[0];

    always_comb begin
        w_new = {bus.ALU_N, bus.ALU_Z, bus.ALU_C, bus.ALU_V};
        if (bus.Ld_direct)
            w_new = bus.D_flags;
        else if (bus.Logic_op)
            w_new = {bus.ALU_N, bus.ALU_Z, bus.Shift_C, w_v_base};
    end

    generate
        if (COMMIT_LAT == 1) begin : g_lat1
            assign w_stage_valid = 1'b0;
            assign r_stage       = 4'b0000;

            always_ff @(posedge Clk or negedge Clr) begin
                if (!Clr) begin
                    r_flags   <= 4'b0000;
                    r_pending <= 1'b0;
                end else begin
                    r_pending <= 1'b0;
                    if (w_req)
                        r_flags <= w_new;
                end
            end
        end else begin : g_lat2
            typedef enum logic {EMPTY, STAGED} state_t;
            state_t     r_state;
            logic [3:0] r_stage_q;

            assign w_stage_valid = (r_state == STAGED);
            assign r_stage       = r_stage_q;

            always_ff @(posedge Clk or negedge Clr) begin
                if (!Clr) begin
                    r_state   <= EMPTY;
                    r_stage_q <= 4'b0000;
                    r_flags   <= 4'b0000;
                    r_pending <= 1'b0;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (w_req) begin
                                r_stage_q <= w_new;
                                r_state   <= STAGED;
                                r_pending <= 1'b1;
                            end
                        end
                        STAGED: begin
                            if (bus.Flush) begin
                                r_stage_q <= 4'b0000;
                                r_state   <= EMPTY;
                                r_pending <= 1'b0;
                            end else begin
                                r_flags <= r_stage_q;
                                if (w_req) begin
                                    r_stage_q <= w_new;
                                    r_pending <= 1'b1;
                                end else begin
                                    r_state   <= EMPTY;
                                    r_pending <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            r_state   <= EMPTY;
                            r_pending <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign bus.N       = r_flags[3];
    assign bus.ZF      = r_flags[2];
    assign bus.C       = r_flags[1];
    assign bus.V       = r_flags[0];
    assign bus.Flags   = r_flags;
    assign bus.Pending = r_pending;
endmodule
